// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_if                                                        |
// | Request, response and memory-side signals of the IF/DM memory arbiter.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [31:0] if_addr;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;

   logic        dm_req_valid;
   logic        dm_req_ready;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_we;
   logic [1:0]  dm_size;
   logic        dm_signed;
   logic        dm_rsp_valid;
   logic [31:0] dm_rsp_data;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic        mem_signed;
   logic [31:0] mem_rdata;

   logic        owner;
   logic        busy;

   // Arbiter side
   modport slave (
      input  if_req_valid, if_addr,
      input  dm_req_valid, dm_addr, dm_wdata, dm_we, dm_size, dm_signed,
      input  mem_rdata,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      output dm_req_ready, dm_rsp_valid, dm_rsp_data,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_signed,
      output owner, busy
   );

   // Requester and memory side
   modport master (
      output if_req_valid, if_addr,
      output dm_req_valid, dm_addr, dm_wdata, dm_we, dm_size, dm_signed,
      output mem_rdata,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_signed,
      input  owner, busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Shares one single-ported memory between instruction fetch and data access. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus_io
);

   localparam int               LAT_W         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT      = LAT_W'(MEM_LATENCY - 1);
   localparam logic [7:0]       STARVE_THRESH = (STARVE_LIMIT > 255) ? 8'd255 : 8'(STARVE_LIMIT);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]       state_q,    state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [LAT_W-1:0] lat_cnt_q,  lat_cnt_d;
   logic [31:0]      addr_q,     addr_d;
   logic [31:0]      wdata_q,    wdata_d;
   logic             we_q,       we_d;
   logic [1:0]       size_q,     size_d;
   logic             signed_q,   signed_d;
   logic             owner_q,    owner_d;
   logic             issue_q,    issue_d;

   logic             idle;
   logic             starved;
   logic             if_grant;
   logic             dm_grant;
   logic             resp;

   assign idle    = (state_q == ST_IDLE);
   assign starved = (wait_cnt_q >= STARVE_THRESH);
   assign resp    = (state_q == ST_RESP);

   // DM wins ties unless IF has been waiting long enough.
   assign if_grant = idle && !reset && bus_io.if_req_valid &&
                     (!bus_io.dm_req_valid || starved);
   assign dm_grant = idle && !reset && bus_io.dm_req_valid && !if_grant;

   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      size_d     = size_q;
      signed_d   = signed_q;
      owner_d    = owner_q;
      issue_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (if_grant) begin
               addr_d    = bus_io.if_addr;
               wdata_d   = 32'h0;
               we_d      = 1'b0;
               size_d    = 2'd2;
               signed_d  = 1'b0;
               owner_d   = 1'b0;
               lat_cnt_d = LAT_INIT;
               issue_d   = 1'b1;
               state_d   = ST_ACCESS;
            end else if (dm_grant) begin
               addr_d    = bus_io.dm_addr;
               wdata_d   = bus_io.dm_wdata;
               we_d      = bus_io.dm_we;
               size_d    = bus_io.dm_size;
               signed_d  = bus_io.dm_signed;
               owner_d   = 1'b1;
               lat_cnt_d = LAT_INIT;
               issue_d   = 1'b1;
               state_d   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (lat_cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!bus_io.if_req_valid || if_grant) begin
         wait_cnt_d = 8'd0;
      end else if (wait_cnt_q != 8'hFF) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 8'd0;
         lat_cnt_q  <= '0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         we_q       <= 1'b0;
         size_q     <= 2'd0;
         signed_q   <= 1'b0;
         owner_q    <= 1'b0;
         issue_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         owner_q    <= owner_d;
         issue_q    <= issue_d;
      end
   end

   assign bus_io.if_req_ready = if_grant;
   assign bus_io.dm_req_ready = dm_grant;

   // Read data passes straight through in the response cycle; stores return 0.
   assign bus_io.if_rsp_valid = resp && !owner_q;
   assign bus_io.if_rsp_data  = (resp && !owner_q) ? bus_io.mem_rdata : 32'h0;
   assign bus_io.dm_rsp_valid = resp && owner_q;
   assign bus_io.dm_rsp_data  = (resp && owner_q && !we_q) ? bus_io.mem_rdata : 32'h0;

   assign bus_io.mem_en     = issue_q;
   assign bus_io.mem_we     = issue_q && we_q;
   assign bus_io.mem_addr   = addr_q;
   assign bus_io.mem_wdata  = wdata_q;
   assign bus_io.mem_size   = size_q;
   assign bus_io.mem_signed = signed_q;

   assign bus_io.owner = owner_q;
   assign bus_io.busy  = !idle;

endmodule
`default_nettype wire
